// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited requests
// to instruction memory, and a small fetch queue feeding decode.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h1C00_0000,
  parameter int unsigned           FETCH_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_inst_req,
  output logic [ADDR_WIDTH-1:0] o_inst_addr,
  input  logic                  i_inst_addr_ok,
  input  logic                  i_inst_data_ok,
  input  logic [DATA_WIDTH-1:0] i_inst_rdata,
  output logic                  o_id_valid,
  output logic [ADDR_WIDTH-1:0] o_id_pc,
  output logic [DATA_WIDTH-1:0] o_id_inst,
  input  logic                  i_id_ready
);

  localparam int unsigned PW = $clog2(FETCH_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]         r_inflight;
  logic [CW-1:0]         r_discard;
  logic [CW-1:0]         r_fq_count;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [ADDR_WIDTH-1:0] r_fq_pc   [FETCH_DEPTH];
  logic [DATA_WIDTH-1:0] r_fq_inst [FETCH_DEPTH];

  logic [SW-1:0]         w_occupancy;
  logic                  w_accept;
  logic                  w_resp;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic                  w_unused_pc_lsbs;

  // Credit counts queued entries plus requests whose responses are still owed.
  assign w_occupancy   = {1'b0, r_fq_count} + {1'b0, r_inflight};
  assign o_inst_req    = !i_redirect_valid && (w_occupancy < SW'(FETCH_DEPTH));
  assign o_inst_addr   = r_fetch_pc;

  assign w_accept      = o_inst_req && i_inst_addr_ok;
  assign w_resp        = i_inst_data_ok && (r_inflight != '0);
  assign w_drop        = w_resp && (r_discard != '0);
  assign w_push        = w_resp && (r_discard == '0) && !i_redirect_valid;
  assign w_pop         = o_id_valid && i_id_ready;
  assign w_redirect_pc = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_pc_lsbs = ^i_redirect_pc[1:0];

  assign o_id_valid    = (r_fq_count != '0);
  assign o_id_pc       = r_fq_pc[r_head];
  assign o_id_inst     = r_fq_inst[r_head];

  // Control state; a redirect overrides every other update in its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_fq_count <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_inflight <= r_inflight - CW'(w_resp);
      r_discard  <= r_inflight - CW'(w_resp);
      r_fq_count <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
      end
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_resp);
      if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + ADDR_WIDTH'(4);
        r_tail    <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_fq_count <= r_fq_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue payload storage needs no reset; validity is tracked by r_fq_count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fq_pc[r_tail]   <= r_resp_pc;
      r_fq_inst[r_tail] <= i_inst_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency and
// a stream-level reference that tracks the next PC decode should receive.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_inst_req       (inst_req),
    .o_inst_addr      (inst_addr),
    .i_inst_addr_ok   (inst_addr_ok),
    .i_inst_data_ok   (inst_data_ok),
    .i_inst_rdata     (inst_rdata),
    .o_id_valid       (id_valid),
    .o_id_pc          (id_pc),
    .o_id_inst        (id_inst),
    .i_id_ready       (id_ready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc, n_acc, n_pop, lat_lo, lat_hi;
  logic [31:0] exp_pc, first_pc;
  logic        s_req, s_valid;
  logic [31:0] s_addr;
  logic [31:0] mem_q[$];
  int          mem_due[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One cycle: drive at negedge, observe handshakes just after, then advance.
  task automatic step(input logic ready, input logic aok, input logic redir,
                      input logic [31:0] rpc);
    id_ready       = ready;
    inst_addr_ok   = aok;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (mem_q.size() != 0 && mem_due[0] <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = inst_of(mem_q[0]);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
    end
    #1;
    s_req   = inst_req;
    s_addr  = inst_addr;
    s_valid = id_valid;
    if (inst_data_ok) begin
      void'(mem_q.pop_front());
      void'(mem_due.pop_front());
    end
    if (inst_req && inst_addr_ok) begin
      mem_q.push_back(inst_addr);
      mem_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
      n_acc++;
    end
    if (redir) begin
      check_eq("req_in_redirect", 32'(inst_req), 32'd0);
      exp_pc = {rpc[31:2], 2'b00};
    end else if (id_valid && id_ready) begin
      if (n_pop == 0) first_pc = id_pc;
      check_eq("id_pc", id_pc, exp_pc);
      check_eq("id_inst", id_inst, inst_of(exp_pc));
      exp_pc += 32'd4;
      n_pop++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = '0;
    id_ready       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_q.delete();
    mem_due.delete();
    exp_pc = RST_PC;
    cyc    = 0;
    n_acc  = 0;
    n_pop  = 0;
    #1;
    check_eq("rst_inst_req", 32'(inst_req), 32'd1);
    check_eq("rst_inst_addr", inst_addr, RST_PC);
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Free run with single-cycle memory: one instruction per cycle from cycle 2.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      check_eq("freerun_valid", 32'(s_valid), (k >= 2) ? 32'd1 : 32'd0);
    end
    check_eq("freerun_count", n_pop, 32'd28);

    // Decode stalled: credit stops at FETCH_DEPTH, then the queue drains in order.
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, '0);
    check_eq("stall_accepts", n_acc, 32'd4);
    check_eq("stall_req_low", 32'(s_req), 32'd0);
    check_eq("stall_full_valid", 32'(s_valid), 32'd1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("stall_drain_count", n_pop, 32'd10);

    // Redirect with two requests in flight; their responses must be dropped.
    lat_lo = 5; lat_hi = 5;
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h1C00_0103);
    step(1'b1, 1'b1, 1'b0, '0);
    check_eq("redir_valid_after", 32'(s_valid), 32'd0);
    check_eq("redir_addr_after", s_addr, 32'h1C00_0100);
    check_eq("redir_req_after", 32'(s_req), 32'd1);
    for (int k = 0; k < 25; k++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("redir_delivered", 32'(n_pop > 0), 32'd1);
    check_eq("redir_first_pc", first_pc, 32'h1C00_0100);

    // Redirect coinciding with a response and a pop of the queue head.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, '0);
    n_pop = 0;
    step(1'b1, 1'b1, 1'b1, 32'h2000_0008);
    check_eq("same_cycle_head_valid", 32'(s_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, '0);
    check_eq("same_cycle_valid_after", 32'(s_valid), 32'd0);
    check_eq("same_cycle_addr_after", s_addr, 32'h2000_0008);
    for (int k = 0; k < 15; k++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("same_cycle_first_pc", first_pc, 32'h2000_0008);

    // Random memory stalls and latencies: 1000 strictly sequential instructions.
    lat_lo = 1; lat_hi = 5;
    do_reset();
    for (int k = 0; k < 20000 && n_pop < 1000; k++)
      step(($urandom % 100) < 70, ($urandom % 100) < 60, 1'b0, '0);
    check_eq("random_delivered", 32'(n_pop >= 1000), 32'd1);

    // Fill the queue mid-stream, then reset.
    lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, '0);
    check_eq("full_valid", 32'(s_valid), 32'd1);
    check_eq("full_req_low", 32'(s_req), 32'd0);
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("post_rst_first_pc", first_pc, RST_PC);
    check_eq("post_rst_count", n_pop, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
